multicycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle Pac-ARM control decoder.
- FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives datapath enables per state.
- Adds full ARM condition evaluation on an internal NZCV flags register, a memory ready handshake with timeout, and a sticky fault state.
- Sits between the instruction register fields, the ALU flag outputs and the shared instruction/data memory port.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/cond_eval.sv | 43 ++++
 rtl/multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle Pac-ARM control unit:
//   - FSM state encoding
//   - instruction-class, condition-code, write-data-source and ALU opcodes
//   - is_wait(): states that hold a memory request open and count toward
//     the memory timeout
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_DP  = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_WB       = 4'd6,
    ST_BRANCH   = 4'd7,
    ST_FAULT    = 4'd8
  } state_e;

  // Instruction class (operation field)
  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_RSV = 2'b11;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Register-file write-data source (selDiWr)
  localparam logic [1:0] DIWR_ALU  = 2'b00;
  localparam logic [1:0] DIWR_OPB  = 2'b01;
  localparam logic [1:0] DIWR_MEM  = 2'b10;
  localparam logic [1:0] DIWR_LINK = 2'b11;

  // ALU opcodes with special handling in the control unit
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  function automatic logic is_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational ARM condition evaluator.
// Ports:
//   cond_i  [3:0]  condition field of the instruction
//   nzcv_i  [3:0]  flags {N, Z, C, V}
//   pass_o         1 when the instruction should execute
// ---------------------------------------------------------------------------
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle Pac-ARM control FSM: FETCH -> DECODE -> EXEC_DP / MEM_ADDR /
// BRANCH -> (MEM_RD / MEM_WR) -> WB, with an internal NZCV register,
// memory-ack timeout and a sticky FAULT state left only by reset.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcodes_i   [5:0]     IR bits [25:20] = {I, opcode[3:0], S/L}
//   operation_i [1:0]     class: 00 DP, 01 load/store, 10 branch, 11 reserved
//   condicion_i [3:0]     condition field
//   aluFlags_i  [3:0]     NZCV from ALU, sampled at end of EXEC_DP
//   memAck_i              memory access done (1-cycle pulse)
//   memReq_o, memWrEn_o, selMemAddr_o    shared memory port control
//   irWrEn_o, pcWrEn_o, selPC_o          IR / PC update
//   regWrEn_o, selAddB_o, selAddWr_o, selDiWr_o [1:0]  register file
//   opALU_o [OPALU_W-1:0], cin_o, selOperaB_o          ALU control
//   flags_o [3:0]         registered NZCV
//   fault_o               sticky fault
// ---------------------------------------------------------------------------
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPALU_W = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcodes_i,
  input  logic [1:0]         operation_i,
  input  logic [3:0]         condicion_i,
  input  logic [3:0]         aluFlags_i,
  input  logic               memAck_i,
  output logic               memReq_o,
  output logic               memWrEn_o,
  output logic               irWrEn_o,
  output logic               pcWrEn_o,
  output logic               selPC_o,
  output logic               regWrEn_o,
  output logic               selAddB_o,
  output logic               selAddWr_o,
  output logic [OPALU_W-1:0] opALU_o,
  output logic               cin_o,
  output logic [1:0]         selDiWr_o,
  output logic               selOperaB_o,
  output logic               selMemAddr_o,
  output logic [3:0]         flags_o,
  output logic               fault_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         flags_q, flags_d;

  logic               mem_req_q, mem_req_d;
  logic               mem_wr_q, mem_wr_d;
  logic               sel_mem_addr_q, sel_mem_addr_d;
  logic               pc_wr_q, pc_wr_d;
  logic               sel_pc_q, sel_pc_d;
  logic               reg_wr_q, reg_wr_d;
  logic               sel_add_b_q, sel_add_b_d;
  logic               sel_add_wr_q, sel_add_wr_d;
  logic [OPALU_W-1:0] op_alu_q, op_alu_d;
  logic               cin_q, cin_d;
  logic [1:0]         sel_di_wr_q, sel_di_wr_d;
  logic               sel_opera_b_q, sel_opera_b_d;
  logic               fault_q, fault_d;

  logic cond_pass;
  logic timeout_hit;
  logic fetch_ack;

  cond_eval u_cond_eval (
    .cond_i (condicion_i),
    .nzcv_i (flags_q),
    .pass_o (cond_pass)
  );

  // Last permitted ack-less cycle of a wait state.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // The IR must capture the word in the same cycle the memory returns it,
  // so the fetch strobes are the only outputs that follow memAck directly.
  assign fetch_ack = (state_q == ST_FETCH) && memAck_i;

  // Next state, wait counter and flags
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      ST_FETCH: begin
        if (memAck_i)         state_d = ST_DECODE;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        if (!cond_pass) begin
          state_d = ST_FETCH;
        end else begin
          case (operation_i)
            CLS_DP:  state_d = ST_EXEC_DP;
            CLS_MEM: state_d = ST_MEM_ADDR;
            CLS_BR:  state_d = ST_BRANCH;
            CLS_RSV: state_d = ST_FAULT;
            default: state_d = ST_FAULT;
          endcase
        end
      end
      ST_EXEC_DP: begin
        if (opcodes_i[0] || (op_alu_q == OPALU_W'(ALU_CMP))) flags_d = aluFlags_i;
        state_d = (op_alu_q == OPALU_W'(ALU_CMP)) ? ST_FETCH : ST_WB;
      end
      ST_MEM_ADDR: state_d = opcodes_i[0] ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (memAck_i)         state_d = ST_WB;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (memAck_i)         state_d = ST_FETCH;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase

    // Counter restarts on every state change, so each wait state entry
    // begins at zero; it only advances while a wait state is stalled.
    if (state_d != state_q)    cnt_d = '0;
    else if (is_wait(state_q)) cnt_d = cnt_q + 1'b1;
    else                       cnt_d = cnt_q;
  end

  // Registered outputs decoded from the state being entered
  always_comb begin
    mem_req_d      = 1'b0;
    mem_wr_d       = 1'b0;
    sel_mem_addr_d = 1'b0;
    pc_wr_d        = 1'b0;
    sel_pc_d       = 1'b0;
    reg_wr_d       = 1'b0;
    sel_add_b_d    = 1'b0;
    sel_add_wr_d   = 1'b0;
    op_alu_d       = '0;
    sel_di_wr_d    = DIWR_ALU;
    sel_opera_b_d  = 1'b0;
    fault_d        = 1'b0;
    case (state_d)
      ST_FETCH: mem_req_d = 1'b1;
      ST_EXEC_DP: begin
        op_alu_d      = OPALU_W'(opcodes_i[4:1]);
        sel_opera_b_d = opcodes_i[5];
      end
      ST_MEM_ADDR: begin
        sel_add_b_d   = 1'b1;
        op_alu_d      = opcodes_i[3] ? OPALU_W'(ALU_ADD) : OPALU_W'(ALU_SUB);
        sel_opera_b_d = ~opcodes_i[5];
      end
      ST_MEM_RD, ST_MEM_WR: begin
        // The ALU keeps producing the data address for the whole access.
        mem_req_d      = 1'b1;
        sel_mem_addr_d = 1'b1;
        mem_wr_d       = (state_d == ST_MEM_WR);
        op_alu_d       = op_alu_q;
        sel_opera_b_d  = sel_opera_b_q;
        sel_add_b_d    = sel_add_b_q;
      end
      ST_WB: begin
        reg_wr_d      = 1'b1;
        op_alu_d      = op_alu_q;
        sel_opera_b_d = sel_opera_b_q;
        sel_add_b_d   = sel_add_b_q;
        if (state_q == ST_MEM_RD)                  sel_di_wr_d = DIWR_MEM;
        else if (op_alu_q == OPALU_W'(ALU_MOV))    sel_di_wr_d = DIWR_OPB;
        else                                       sel_di_wr_d = DIWR_ALU;
      end
      ST_BRANCH: begin
        pc_wr_d  = 1'b1;
        sel_pc_d = 1'b1;
        if (!opcodes_i[4]) begin
          reg_wr_d     = 1'b1;
          sel_add_wr_d = 1'b1;
          sel_di_wr_d  = DIWR_LINK;
        end
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
    cin_d = (op_alu_d == OPALU_W'(ALU_SUB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FETCH;
      cnt_q          <= '0;
      flags_q        <= 4'b0000;
      mem_req_q      <= 1'b0;
      mem_wr_q       <= 1'b0;
      sel_mem_addr_q <= 1'b0;
      pc_wr_q        <= 1'b0;
      sel_pc_q       <= 1'b0;
      reg_wr_q       <= 1'b0;
      sel_add_b_q    <= 1'b0;
      sel_add_wr_q   <= 1'b0;
      op_alu_q       <= '0;
      cin_q          <= 1'b0;
      sel_di_wr_q    <= 2'b00;
      sel_opera_b_q  <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flags_q        <= flags_d;
      mem_req_q      <= mem_req_d;
      mem_wr_q       <= mem_wr_d;
      sel_mem_addr_q <= sel_mem_addr_d;
      pc_wr_q        <= pc_wr_d;
      sel_pc_q       <= sel_pc_d;
      reg_wr_q       <= reg_wr_d;
      sel_add_b_q    <= sel_add_b_d;
      sel_add_wr_q   <= sel_add_wr_d;
      op_alu_q       <= op_alu_d;
      cin_q          <= cin_d;
      sel_di_wr_q    <= sel_di_wr_d;
      sel_opera_b_q  <= sel_opera_b_d;
      fault_q        <= fault_d;
    end
  end

  assign memReq_o     = mem_req_q;
  assign memWrEn_o    = mem_wr_q;
  assign selMemAddr_o = sel_mem_addr_q;
  assign irWrEn_o     = fetch_ack;
  assign pcWrEn_o     = pc_wr_q | fetch_ack;
  assign selPC_o      = sel_pc_q;
  assign regWrEn_o    = reg_wr_q;
  assign selAddB_o    = sel_add_b_q;
  assign selAddWr_o   = sel_add_wr_q;
  assign opALU_o      = op_alu_q;
  assign cin_o        = cin_q;
  assign selDiWr_o    = sel_di_wr_q;
  assign selOperaB_o  = sel_opera_b_q;
  assign flags_o      = flags_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed bench for multicycle_control_unit. Each task drives one scenario
// and checks outputs a couple of ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcodes;
  logic [1:0] operation;
  logic [3:0] condicion;
  logic [3:0] aluFlags;
  logic       memAck;
  logic       memReq, memWrEn, irWrEn, pcWrEn, selPC, regWrEn;
  logic       selAddB, selAddWr, cin, selOperaB, selMemAddr, fault;
  logic [3:0] opALU;
  logic [1:0] selDiWr;
  logic [3:0] flags;

  int checks   = 0;
  int failures = 0;

  multicycle_control_unit #(.OPALU_W(4), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcodes_i    (opcodes),
    .operation_i  (operation),
    .condicion_i  (condicion),
    .aluFlags_i   (aluFlags),
    .memAck_i     (memAck),
    .memReq_o     (memReq),
    .memWrEn_o    (memWrEn),
    .irWrEn_o     (irWrEn),
    .pcWrEn_o     (pcWrEn),
    .selPC_o      (selPC),
    .regWrEn_o    (regWrEn),
    .selAddB_o    (selAddB),
    .selAddWr_o   (selAddWr),
    .opALU_o      (opALU),
    .cin_o        (cin),
    .selDiWr_o    (selDiWr),
    .selOperaB_o  (selOperaB),
    .selMemAddr_o (selMemAddr),
    .flags_o      (flags),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reset, release, and let one edge pass so FETCH's request is visible.
  task automatic do_reset();
    rst_n = 1'b0; opcodes = '0; operation = '0; condicion = 4'hE;
    aluFlags = '0; memAck = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One-cycle ack in the current FETCH cycle; returns in DECODE.
  task automatic fetch_ack();
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcodes = '0; operation = '0; condicion = 4'hE;
    aluFlags = '0; memAck = 1'b0;
    tick();
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL rst_memReq: got %b want 0", memReq); end
    checks++; if (regWrEn !== 1'b0) begin failures++; $display("FAIL rst_regWrEn: got %b want 0", regWrEn); end
    checks++; if (pcWrEn !== 1'b0) begin failures++; $display("FAIL rst_pcWrEn: got %b want 0", pcWrEn); end
    checks++; if (opALU !== 4'b0000) begin failures++; $display("FAIL rst_opALU: got %b want 0000", opALU); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL rst_flags: got %b want 0000", flags); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", fault); end
    rst_n = 1'b1;
    tick();
    checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL rst_fetch_memReq: got %b want 1", memReq); end
    checks++; if (selMemAddr !== 1'b0) begin failures++; $display("FAIL rst_fetch_selMemAddr: got %b want 0", selMemAddr); end
    $display("TXN reset: checks so far %0d", checks);
  endtask

  task automatic test_add_s();
    do_reset();
    operation = 2'b00; condicion = 4'hE; opcodes = 6'b0_0100_1;
    memAck = 1'b1; #1;
    checks++; if (irWrEn !== 1'b1) begin failures++; $display("FAIL add_irWrEn: got %b want 1", irWrEn); end
    checks++; if (pcWrEn !== 1'b1 || selPC !== 1'b0) begin failures++; $display("FAIL add_pc_inc: got pcWrEn=%b selPC=%b want 1/0", pcWrEn, selPC); end
    tick(); memAck = 1'b0;
    checks++; if (memReq !== 1'b0 || regWrEn !== 1'b0) begin failures++; $display("FAIL add_decode: got memReq=%b regWrEn=%b want 0/0", memReq, regWrEn); end
    tick();
    aluFlags = 4'b0100;
    checks++; if (opALU !== 4'b0100 || cin !== 1'b0 || selOperaB !== 1'b0) begin failures++; $display("FAIL add_exec: got opALU=%b cin=%b selOperaB=%b want 0100/0/0", opALU, cin, selOperaB); end
    tick();
    aluFlags = 4'b0000;
    checks++; if (regWrEn !== 1'b1) begin failures++; $display("FAIL add_wb_regWrEn: got %b want 1", regWrEn); end
    checks++; if (selDiWr !== 2'b00) begin failures++; $display("FAIL add_wb_selDiWr: got %b want 00", selDiWr); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL add_flags: got %b want 0100", flags); end
    tick();
    checks++; if (memReq !== 1'b1 || regWrEn !== 1'b0) begin failures++; $display("FAIL add_refetch: got memReq=%b regWrEn=%b want 1/0", memReq, regWrEn); end
    $display("TXN ADDS: regWrEn in cycle 4, flags=%b", flags);
  endtask

  task automatic test_cmp_bne();
    do_reset();
    operation = 2'b00; condicion = 4'hE; opcodes = 6'b0_1010_1;
    fetch_ack();
    tick();
    aluFlags = 4'b0100;
    checks++; if (opALU !== 4'b1010 || regWrEn !== 1'b0) begin failures++; $display("FAIL cmp_exec: got opALU=%b regWrEn=%b want 1010/0", opALU, regWrEn); end
    tick();
    aluFlags = 4'b0000;
    checks++; if (regWrEn !== 1'b0 || memReq !== 1'b1) begin failures++; $display("FAIL cmp_nowrite: got regWrEn=%b memReq=%b want 0/1", regWrEn, memReq); end
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL cmp_flags: got %b want 0100", flags); end
    // BNE with Z set: condition fails
    operation = 2'b10; condicion = 4'b0001; opcodes = 6'b010000;
    fetch_ack();
    checks++; if (pcWrEn !== 1'b0 || selPC !== 1'b0) begin failures++; $display("FAIL bne_decode: got pcWrEn=%b selPC=%b want 0/0", pcWrEn, selPC); end
    tick();
    checks++; if (memReq !== 1'b1 || pcWrEn !== 1'b0 || regWrEn !== 1'b0) begin failures++; $display("FAIL bne_skip: got memReq=%b pcWrEn=%b regWrEn=%b want 1/0/0", memReq, pcWrEn, regWrEn); end
    memAck = 1'b1; #1;
    checks++; if (pcWrEn !== 1'b1 || selPC !== 1'b0) begin failures++; $display("FAIL bne_pc4: got pcWrEn=%b selPC=%b want 1/0", pcWrEn, selPC); end
    tick(); memAck = 1'b0;
    $display("TXN CMP+BNE: BNE not taken");
  endtask

  task automatic test_ldr();
    do_reset();
    operation = 2'b01; condicion = 4'hE; opcodes = 6'b001001;
    fetch_ack();
    tick();
    checks++; if (selAddB !== 1'b1 || opALU !== 4'b0100 || selOperaB !== 1'b1 || memReq !== 1'b0) begin failures++; $display("FAIL ldr_addr: got selAddB=%b opALU=%b selOperaB=%b memReq=%b want 1/0100/1/0", selAddB, opALU, selOperaB, memReq); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (memReq !== 1'b1 || selMemAddr !== 1'b1 || memWrEn !== 1'b0 || regWrEn !== 1'b0) begin failures++; $display("FAIL ldr_wait%0d: got memReq=%b selMemAddr=%b memWrEn=%b regWrEn=%b want 1/1/0/0", i, memReq, selMemAddr, memWrEn, regWrEn); end
      tick();
    end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checks++; if (regWrEn !== 1'b1 || selDiWr !== 2'b10 || memReq !== 1'b0) begin failures++; $display("FAIL ldr_wb: got regWrEn=%b selDiWr=%b memReq=%b want 1/10/0", regWrEn, selDiWr, memReq); end
    tick();
    checks++; if (memReq !== 1'b1 || selMemAddr !== 1'b0 || regWrEn !== 1'b0) begin failures++; $display("FAIL ldr_refetch: got memReq=%b selMemAddr=%b regWrEn=%b want 1/0/0", memReq, selMemAddr, regWrEn); end
    $display("TXN LDR: ack after 3 wait cycles, WB selDiWr=%b", 2'b10);
  endtask

  task automatic test_bl();
    do_reset();
    operation = 2'b10; condicion = 4'hE; opcodes = 6'b000000;
    fetch_ack();
    tick();
    checks++; if (pcWrEn !== 1'b1 || selPC !== 1'b1) begin failures++; $display("FAIL bl_pc: got pcWrEn=%b selPC=%b want 1/1", pcWrEn, selPC); end
    checks++; if (regWrEn !== 1'b1 || selAddWr !== 1'b1 || selDiWr !== 2'b11) begin failures++; $display("FAIL bl_link: got regWrEn=%b selAddWr=%b selDiWr=%b want 1/1/11", regWrEn, selAddWr, selDiWr); end
    tick();
    checks++; if (memReq !== 1'b1 || pcWrEn !== 1'b0 || regWrEn !== 1'b0) begin failures++; $display("FAIL bl_refetch: got memReq=%b pcWrEn=%b regWrEn=%b want 1/0/0", memReq, pcWrEn, regWrEn); end
    $display("TXN BL: branch with link");
  endtask

  task automatic test_store_reset();
    do_reset();
    operation = 2'b00; condicion = 4'hE; opcodes = 6'b0_0100_1;
    fetch_ack();
    tick();
    aluFlags = 4'b1001;
    tick();
    aluFlags = 4'b0000;
    tick();
    checks++; if (flags !== 4'b1001) begin failures++; $display("FAIL str_preflags: got %b want 1001", flags); end
    operation = 2'b01; opcodes = 6'b001000;
    fetch_ack();
    tick();
    tick();
    checks++; if (memWrEn !== 1'b1 || memReq !== 1'b1) begin failures++; $display("FAIL str_memwr: got memWrEn=%b memReq=%b want 1/1", memWrEn, memReq); end
    rst_n = 1'b0; #1;
    checks++; if (memWrEn !== 1'b0 || memReq !== 1'b0) begin failures++; $display("FAIL str_abort: got memWrEn=%b memReq=%b want 0/0", memWrEn, memReq); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (memReq !== 1'b1 || selMemAddr !== 1'b0 || flags !== 4'b0000) begin failures++; $display("FAIL str_after_rst: got memReq=%b selMemAddr=%b flags=%b want 1/0/0000", memReq, selMemAddr, flags); end
    $display("TXN STR aborted by reset");
  endtask

  task automatic test_timeout();
    do_reset();
    // Never-condition instruction: 2-cycle no-op that re-enters FETCH fresh.
    operation = 2'b00; condicion = 4'hF; opcodes = 6'b0_0100_1;
    fetch_ack();
    checks++; if (memReq !== 1'b0 || regWrEn !== 1'b0) begin failures++; $display("FAIL nv_decode: got memReq=%b regWrEn=%b want 0/0", memReq, regWrEn); end
    tick();
    checks++; if (memReq !== 1'b1 || regWrEn !== 1'b0) begin failures++; $display("FAIL nv_refetch: got memReq=%b regWrEn=%b want 1/0", memReq, regWrEn); end
    for (int i = 0; i < 15; i++) begin
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL to_early%0d: got fault=%b want 0", i, fault); end
      tick();
    end
    checks++; if (fault !== 1'b1 || memReq !== 1'b0) begin failures++; $display("FAIL to_fault: got fault=%b memReq=%b want 1/0", fault, memReq); end
    memAck = 1'b1; #1;
    checks++; if (irWrEn !== 1'b0 || pcWrEn !== 1'b0) begin failures++; $display("FAIL to_ack_ignored: got irWrEn=%b pcWrEn=%b want 0/0", irWrEn, pcWrEn); end
    tick();
    memAck = 1'b0;
    repeat (3) tick();
    checks++; if (fault !== 1'b1 || memReq !== 1'b0) begin failures++; $display("FAIL to_sticky: got fault=%b memReq=%b want 1/0", fault, memReq); end
    rst_n = 1'b0; #1;
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL to_reset_clears: got fault=%b want 0", fault); end
    tick();
    rst_n = 1'b1;
    tick();
    $display("TXN timeout: fault after 15 ack-less FETCH cycles");
  endtask

  initial begin
    rst_n = 1'b0; opcodes = '0; operation = '0; condicion = 4'hE;
    aluFlags = '0; memAck = 1'b0;
    test_reset();
    test_add_s();
    test_cmp_bne();
    test_ldr();
    test_bl();
    test_store_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
